// File: rtl/song_sequencer_pkg.sv
// song_pkg: note codes, pitch table, half-period helper and sequencer states
// shared by song_sequencer and tone_gen.
package song_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_AS4  = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam int unsigned FREQ_C4  = 261;
  localparam int unsigned FREQ_D4  = 293;
  localparam int unsigned FREQ_E4  = 329;
  localparam int unsigned FREQ_F4  = 349;
  localparam int unsigned FREQ_G4  = 392;
  localparam int unsigned FREQ_A4  = 440;
  localparam int unsigned FREQ_AS4 = 466;
  localparam int unsigned FREQ_C5  = 523;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Pitch in Hz for a note code; 0 marks anything that is silent (rests, END).
  function automatic int unsigned note_freq(input logic [3:0] code);
    case (code)
      NOTE_C4:  return FREQ_C4;
      NOTE_D4:  return FREQ_D4;
      NOTE_E4:  return FREQ_E4;
      NOTE_F4:  return FREQ_F4;
      NOTE_G4:  return FREQ_G4;
      NOTE_A4:  return FREQ_A4;
      NOTE_AS4: return FREQ_AS4;
      NOTE_C5:  return FREQ_C5;
      default:  return 0;
    endcase
  endfunction

  // Clock cycles per half period of the square wave; 0 means silent.
  function automatic int unsigned half_period(input logic [3:0] code,
                                              input int unsigned clk_hz);
    int unsigned f;
    f = note_freq(code);
    if (f == 0) return 0;
    return clk_hz / (2 * f);
  endfunction

endpackage

// File: rtl/song_sequencer_tone_gen.sv
// tone_gen: square-wave generator for one voice. load restarts the phase
// (divider cleared, output low); silent codes hold the output low.
module tone_gen
  import song_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned DIV_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] code,
  output logic       speaker
);

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] div_cnt;

  // Half-period lookup for the current code, truncated to the divider width.
  always_comb begin
    half = DIV_W'(half_period(code, CLK_HZ));
  end

  // Divider: toggle the output each time half-period cycles have elapsed.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      div_cnt <= '0;
      speaker <= 1'b0;
    end else if (half == '0) begin
      div_cnt <= '0;
      speaker <= 1'b0;
    end else if (div_cnt == half - DIV_W'(1)) begin
      div_cnt <= '0;
      speaker <= ~speaker;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM of (note, duration) entries and plays each
// note on the speaker pin, timed by a tempo tick. Supports start/stop, looping,
// rests and END markers.
// Optional macro NOTE_GAP_EN: inserts one silent tempo tick after every note.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned TICK_DIV = 750000,
  parameter int unsigned SONG_LEN = 26,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DUR_W    = 3,
  parameter int unsigned DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic              busy,
  output logic [3:0]        note_idx,
  output logic              speaker
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_next;
  logic [TICK_W-1:0] tick_cnt, tick_next;
  logic [DUR_W-1:0]  dur_cnt, dur_cnt_next;
  logic [DUR_W-1:0]  dur_reg, dur_reg_next;
  logic [3:0]        note_reg, note_reg_next;
  logic [3:0]        note_idx_next;
  logic              tick_wrap;
  logic              note_done;
  logic              seq_advance;
  logic              seq_end;
  logic              tone_load;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      dur_reg  <= '0;
      note_reg <= NOTE_REST;
      note_idx <= '0;
    end else begin
      state    <= state_next;
      rom_addr <= addr_next;
      tick_cnt <= tick_next;
      dur_cnt  <= dur_cnt_next;
      dur_reg  <= dur_reg_next;
      note_reg <= note_reg_next;
      note_idx <= note_idx_next;
    end
  end

  // Next-state and datapath logic. "Advance" and "end of song" are raised as
  // flags inside the case and resolved afterwards, since PLAY, GAP and LOAD
  // all share them; stop overrides everything last.
  always_comb begin
    state_next    = state;
    addr_next     = rom_addr;
    tick_next     = tick_cnt;
    dur_cnt_next  = dur_cnt;
    dur_reg_next  = dur_reg;
    note_reg_next = note_reg;
    note_idx_next = note_idx;
    seq_advance   = 1'b0;
    seq_end       = 1'b0;
    tick_wrap     = (tick_cnt == TICK_LAST);
    note_done     = tick_wrap && (dur_cnt == dur_reg);

    case (state)
      ST_IDLE: begin
        tick_next    = '0;
        dur_cnt_next = '0;
        if (start) begin
          state_next = ST_FETCH;
          addr_next  = '0;
        end
      end
      ST_FETCH: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        note_reg_next = rom_note;
        dur_reg_next  = rom_dur;
        if (rom_note == NOTE_END) begin
          seq_end = 1'b1;
        end else begin
          state_next    = ST_PLAY;
          tick_next     = '0;
          dur_cnt_next  = '0;
          note_idx_next = rom_note;
        end
      end
      ST_PLAY: begin
        tick_next = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
        if (tick_wrap) dur_cnt_next = dur_cnt + DUR_W'(1);
        if (note_done) begin
`ifdef NOTE_GAP_EN
          state_next    = ST_GAP;
          tick_next     = '0;
          note_idx_next = '0;
`else
          seq_advance = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        tick_next = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
        if (tick_wrap) seq_advance = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (seq_advance) begin
      if (rom_addr == ADDR_LAST) begin
        seq_end = 1'b1;
      end else begin
        addr_next  = rom_addr + ADDR_W'(1);
        state_next = ST_FETCH;
      end
    end

    if (seq_end) begin
      addr_next = '0;
      if (loop) begin
        state_next = ST_FETCH;
      end else begin
        state_next    = ST_IDLE;
        note_idx_next = '0;
      end
    end

    if (stop) begin
      state_next    = ST_IDLE;
      addr_next     = '0;
      tick_next     = '0;
      dur_cnt_next  = '0;
      note_idx_next = '0;
    end
  end

  // Busy flag and tone restart control. The tone is reloaded (silenced and
  // phase-reset) on every edge that does not continue a PLAY, so the speaker
  // is low from the first cycle outside PLAY and each note starts in phase.
  always_comb begin
    busy      = (state != ST_IDLE);
    tone_load = (state == ST_LOAD) || (state_next != ST_PLAY);
  end

  tone_gen #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .load    (tone_load),
    .code    (note_reg),
    .speaker (speaker)
  );

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench. Each song start pushes the expected
// per-cycle outputs (busy, speaker, rom_addr, note_idx) into a queue built
// from the song table and the documented timing; records are popped and
// compared every falling edge.
module tb_song_sequencer;

  localparam int unsigned CLK_HZ   = 2620;
  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned SONG_LEN = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DUR_W    = 3;
`ifdef NOTE_GAP_EN
  localparam int unsigned GAP_CYC  = TICK_DIV;
`else
  localparam int unsigned GAP_CYC  = 0;
`endif

  typedef struct {
    logic       busy;
    logic       spk;
    logic [1:0] addr;
    logic [3:0] note;
    bit         note_dc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_note = '0;
  logic [DUR_W-1:0]  rom_dur = '0;
  logic              busy;
  logic [3:0]        note_idx;
  logic              speaker;

  logic [3:0]       song_note [SONG_LEN];
  logic [DUR_W-1:0] song_dur  [SONG_LEN];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   test_id = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  always @(posedge clk) begin
    rom_note <= song_note[rom_addr];
    rom_dur  <= song_dur[rom_addr];
  end

  song_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_DIV (TICK_DIV),
    .SONG_LEN (SONG_LEN),
    .ADDR_W   (ADDR_W),
    .DUR_W    (DUR_W),
    .DIV_W    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .rom_addr (rom_addr),
    .rom_note (rom_note),
    .rom_dur  (rom_dur),
    .busy     (busy),
    .note_idx (note_idx),
    .speaker  (speaker)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic int unsigned tb_half(input logic [3:0] code);
    int unsigned f;
    case (code)
      4'd1: f = 261;
      4'd2: f = 293;
      4'd3: f = 329;
      4'd4: f = 349;
      4'd5: f = 392;
      4'd6: f = 440;
      4'd7: f = 466;
      4'd8: f = 523;
      default: f = 0;
    endcase
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  task automatic push(input logic b, input logic s, input logic [1:0] a,
                      input logic [3:0] n, input bit dc);
    exp_t e;
    e.busy = b; e.spk = s; e.addr = a; e.note = n; e.note_dc = dc;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  // Expected trace from the first cycle after start is accepted.
  task automatic gen_trace(input bit lp, input int unsigned passes);
    int unsigned len, hp;
    logic [3:0] code;
    for (int unsigned p = 0; p < passes; p++) begin
      for (int unsigned a = 0; a < SONG_LEN; a++) begin
        push(1'b1, 1'b0, 2'(a), 4'd0, 1'b1);   // FETCH
        push(1'b1, 1'b0, 2'(a), 4'd0, 1'b1);   // LOAD
        code = song_note[a];
        if (code == 4'd15) begin
          if (!lp) begin
            push_idle(1);
            return;
          end
          break;
        end
        len = (int'(song_dur[a]) + 1) * TICK_DIV;
        hp  = tb_half(code);
        for (int unsigned k = 0; k < len; k++)
          push(1'b1, (hp == 0) ? 1'b0 : 1'((k / hp) % 2), 2'(a), code, 1'b0);
        for (int unsigned k = 0; k < GAP_CYC; k++)
          push(1'b1, 1'b0, 2'(a), 4'd0, 1'b0);
      end
    end
    if (!lp) push_idle(1);
  endtask

  // Pop and compare up to n records, one per falling edge.
  task automatic run_n(input int unsigned n);
    exp_t e;
    logic [7:0] got, want;
    for (int unsigned i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      cyc++;
      e    = exp_q.pop_front();
      got  = {busy, speaker, rom_addr, e.note_dc ? 4'd0 : note_idx};
      want = {e.busy, e.spk, e.addr, e.note_dc ? 4'd0 : e.note};
      check_val($sformatf("t%0d_c%0d_{busy,spk,addr,note}", test_id, cyc),
                32'(got), 32'(want));
    end
  endtask

  task automatic set_song(input logic [3:0] n0, input logic [3:0] n1,
                          input logic [3:0] n2, input logic [3:0] n3);
    song_note[0] = n0; song_dur[0] = 3'd1;
    song_note[1] = n1; song_dur[1] = 3'd0;
    song_note[2] = n2; song_dur[2] = 3'd0;
    song_note[3] = n3; song_dur[3] = 3'd0;
  endtask

  initial begin
    set_song(4'd1, 4'd6, 4'd0, 4'd5);   // C dur1, A, rest, G

    // Reset state
    test_id = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_idle(1);
    run_n(1);

    // 1: single pass, with start pulses while busy that must be ignored
    test_id = 1; cyc = 0;
    loop = 1'b0;
    start = 1'b1;
    gen_trace(1'b0, 1);
    run_n(1);
    start = 1'b0;
    run_n(6);
    start = 1'b1;
    run_n(1);
    start = 1'b0;
    run_n(20);
    start = 1'b1;
    run_n(1);
    start = 1'b0;
    run_n(exp_q.size());
    push_idle(3);
    run_n(3);

    // 2: loop over three passes, then stop
    test_id = 2; cyc = 0;
    loop = 1'b1;
    start = 1'b1;
    gen_trace(1'b1, 3);
    run_n(1);
    start = 1'b0;
    run_n(exp_q.size());
    stop = 1'b1;
    push_idle(1);
    run_n(1);
    stop = 1'b0;
    loop = 1'b0;
    push_idle(2);
    run_n(2);

    // 3: END marker in entry 1 ends the song after entry 0
    test_id = 3; cyc = 0;
    set_song(4'd1, 4'd15, 4'd0, 4'd5);
    start = 1'b1;
    gen_trace(1'b0, 1);
    run_n(1);
    start = 1'b0;
    run_n(exp_q.size());
    push_idle(2);
    run_n(2);

    // 4: stop during PLAY of entry 1, with a simultaneous start
    test_id = 4; cyc = 0;
    set_song(4'd1, 4'd6, 4'd0, 4'd5);
    start = 1'b1;
    gen_trace(1'b0, 1);
    run_n(1);
    start = 1'b0;
    run_n(1 + 20 + GAP_CYC + 2 + 5);
    exp_q.delete();
    stop = 1'b1;
    start = 1'b1;
    push_idle(1);
    run_n(1);
    stop = 1'b0;
    start = 1'b0;
    push_idle(3);
    run_n(3);

    // 5: reset in the middle of PLAY
    test_id = 5; cyc = 0;
    start = 1'b1;
    gen_trace(1'b0, 1);
    run_n(1);
    start = 1'b0;
    run_n(8);
    exp_q.delete();
    rst = 1'b1;
    push_idle(1);
    run_n(1);
    rst = 1'b0;
    push_idle(2);
    run_n(2);

    // 6: looped song with END at entry 2 wraps back to address 0
    test_id = 6; cyc = 0;
    set_song(4'd8, 4'd3, 4'd15, 4'd5);
    loop = 1'b1;
    start = 1'b1;
    gen_trace(1'b1, 2);
    run_n(1);
    start = 1'b0;
    run_n(exp_q.size());
    stop = 1'b1;
    push_idle(1);
    run_n(1);
    stop = 1'b0;
    loop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
